// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: widths, reset level,
// load/store opcodes and the opcode decoder used by the lane aligner.
package mem_stage_pkg;

    localparam int BUS_W_DEF  = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int OP_W_DEF   = 8;

    localparam logic RST_ENABLE = 1'b0;

    localparam logic [OP_W_DEF-1:0] EXE_OR_OP  = 8'b0010_0101;
    localparam logic [OP_W_DEF-1:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [OP_W_DEF-1:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [OP_W_DEF-1:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [OP_W_DEF-1:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [OP_W_DEF-1:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [OP_W_DEF-1:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [OP_W_DEF-1:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [OP_W_DEF-1:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic {S_IDLE, S_BUSY} state_e;

    typedef enum logic [1:0] {SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

    typedef struct packed {
        logic  is_store;
        logic  sign;
        size_e size;
    } mem_op_t;

    function automatic mem_op_t decode_op(input logic [OP_W_DEF-1:0] aluop);
        mem_op_t op;
        op.is_store = 1'b0;
        op.sign     = 1'b0;
        op.size     = SZ_NONE;
        case (aluop)
            EXE_LB_OP:  begin op.size = SZ_BYTE; op.sign = 1'b1; end
            EXE_LBU_OP: op.size = SZ_BYTE;
            EXE_LH_OP:  begin op.size = SZ_HALF; op.sign = 1'b1; end
            EXE_LHU_OP: op.size = SZ_HALF;
            EXE_LW_OP:  op.size = SZ_WORD;
            EXE_SB_OP:  begin op.size = SZ_BYTE; op.is_store = 1'b1; end
            EXE_SH_OP:  begin op.size = SZ_HALF; op.is_store = 1'b1; end
            EXE_SW_OP:  begin op.size = SZ_WORD; op.is_store = 1'b1; end
            default:    ;
        endcase
        return op;
    endfunction

    function automatic logic is_mem_op(input logic [OP_W_DEF-1:0] aluop);
        return aluop inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP,
                             EXE_LW_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    endfunction

    function automatic logic is_store_op(input logic [OP_W_DEF-1:0] aluop);
        return aluop inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Single-outstanding req/ack data bus between the memory stage and memory.
interface mem_stage_if #(parameter int BUS_W = 32);

    logic             req;
    logic             we;
    logic [BUS_W-1:0] addr;
    logic [3:0]       sel;
    logic [BUS_W-1:0] wdata;
    logic [BUS_W-1:0] rdata;
    logic             ack;

    modport master (output req, we, addr, sel, wdata, input rdata, ack);
    modport slave  (input req, we, addr, sel, wdata, output rdata, ack);

endinterface

// File: rtl/mem_lane_align.sv
// Combinational big-endian lane steering: byte selects, store replication,
// load extraction with sign/zero extension, and the alignment check.
module mem_lane_align
    import mem_stage_pkg::*;
#(
    parameter int BUS_W = BUS_W_DEF,
    parameter int OP_W  = OP_W_DEF
) (
    input  logic [OP_W-1:0]  aluop,
    input  logic [1:0]       addr_lo,
    input  logic [BUS_W-1:0] store_data,
    input  logic [BUS_W-1:0] rdata,
    output logic [3:0]       sel,
    output logic [BUS_W-1:0] wdata,
    output logic [BUS_W-1:0] load_data,
    output logic             misaligned
);

    mem_op_t     op;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    assign op = decode_op(aluop);

    // Offset 0 lives in bits 31:24, offset 3 in bits 7:0.
    always_comb begin
        case (addr_lo)
            2'd0:    lane_byte = rdata[31:24];
            2'd1:    lane_byte = rdata[23:16];
            2'd2:    lane_byte = rdata[15:8];
            default: lane_byte = rdata[7:0];
        endcase
        lane_half = addr_lo[1] ? rdata[15:0] : rdata[31:16];
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path infers a latch.
        sel        = '0;
        wdata      = '0;
        load_data  = '0;
        misaligned = 1'b0;
        case (op.size)
            SZ_BYTE: begin
                sel       = 4'b1000 >> addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = op.sign ? {{(BUS_W-8){lane_byte[7]}}, lane_byte}
                                    : {{(BUS_W-8){1'b0}}, lane_byte};
            end
            SZ_HALF: begin
                misaligned = addr_lo[0];
                sel        = addr_lo[1] ? 4'b0011 : 4'b1100;
                wdata      = {2{store_data[15:0]}};
                load_data  = op.sign ? {{(BUS_W-16){lane_half[15]}}, lane_half}
                                     : {{(BUS_W-16){1'b0}}, lane_half};
            end
            SZ_WORD: begin
                misaligned = (addr_lo != 2'b00);
                sel        = 4'b1111;
                wdata      = store_data;
                load_data  = rdata;
            end
            default: ;
        endcase
        if (!op.is_store) wdata = '0;
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores on a single-outstanding
// bus, stalls the pipeline while in flight, and registers the MEM/WB triple.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int BUS_W  = BUS_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int OP_W   = OP_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic              flush_i,
    input  logic [OP_W-1:0]   aluop_i,
    input  logic [ADDR_W-1:0] wd_i,
    input  logic              wreg_i,
    input  logic [BUS_W-1:0]  wdata_i,
    input  logic [BUS_W-1:0]  mem_addr_i,
    input  logic [BUS_W-1:0]  reg2_i,
    mem_stage_if.master       bus,
    output logic              stallreq_o,
    output logic              misalign_o,
    output logic [ADDR_W-1:0] wd_o,
    output logic              wreg_o,
    output logic [BUS_W-1:0]  wdata_o
);

    state_e            state_q, state_d;
    logic              discard_q;
    logic [OP_W-1:0]   lat_aluop;
    logic [1:0]        lat_addr_lo;
    logic [ADDR_W-1:0] lat_wd;
    logic              lat_wreg;

    logic              live;
    logic              in_mem;
    logic              issue;
    logic              mis_hit;
    logic [OP_W-1:0]   cur_aluop;
    logic [1:0]        cur_addr_lo;
    logic [3:0]        lane_sel;
    logic [BUS_W-1:0]  lane_wdata;
    logic [BUS_W-1:0]  load_data;
    logic              misaligned;

    assign live   = valid_i && !flush_i;
    assign in_mem = is_mem_op(aluop_i);

    // While busy, extension uses the opcode/offset captured at issue.
    assign cur_aluop   = (state_q == S_BUSY) ? lat_aluop   : aluop_i;
    assign cur_addr_lo = (state_q == S_BUSY) ? lat_addr_lo : mem_addr_i[1:0];

    assign issue   = (state_q == S_IDLE) && live && in_mem && !misaligned;
    assign mis_hit = (state_q == S_IDLE) && live && in_mem &&  misaligned;

    mem_lane_align #(
        .BUS_W (BUS_W),
        .OP_W  (OP_W)
    ) u_align (
        .aluop      (cur_aluop),
        .addr_lo    (cur_addr_lo),
        .store_data (reg2_i),
        .rdata      (bus.rdata),
        .sel        (lane_sel),
        .wdata      (lane_wdata),
        .load_data  (load_data),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (rst == RST_ENABLE) state_q <= S_IDLE;
        else                   state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        stallreq_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (issue) begin
                    stallreq_o = 1'b1;
                    state_d    = S_BUSY;
                end
            end
            S_BUSY: begin
                // Releasing the stall in the ack cycle lets the pipeline advance on the same edge.
                if (bus.ack) state_d    = S_IDLE;
                else         stallreq_o = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            bus.req     <= 1'b0;
            bus.we      <= 1'b0;
            bus.addr    <= '0;
            bus.sel     <= '0;
            bus.wdata   <= '0;
            discard_q   <= 1'b0;
            lat_aluop   <= '0;
            lat_addr_lo <= '0;
            lat_wd      <= '0;
            lat_wreg    <= 1'b0;
            wd_o        <= '0;
            wreg_o      <= 1'b0;
            wdata_o     <= '0;
            misalign_o  <= 1'b0;
        end else begin
            // Any cycle without a result registers a bubble so WB never writes twice.
            wd_o       <= '0;
            wreg_o     <= 1'b0;
            wdata_o    <= '0;
            misalign_o <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (issue) begin
                        bus.req     <= 1'b1;
                        bus.we      <= is_store_op(aluop_i);
                        bus.addr    <= {mem_addr_i[BUS_W-1:2], 2'b00};
                        bus.sel     <= lane_sel;
                        bus.wdata   <= lane_wdata;
                        discard_q   <= 1'b0;
                        lat_aluop   <= aluop_i;
                        lat_addr_lo <= mem_addr_i[1:0];
                        lat_wd      <= wd_i;
                        lat_wreg    <= wreg_i;
                    end else if (mis_hit) begin
                        misalign_o <= 1'b1;
                    end else if (live) begin
                        wd_o    <= wd_i;
                        wreg_o  <= wreg_i;
                        wdata_o <= wdata_i;
                    end
                end
                S_BUSY: begin
                    if (bus.ack) begin
                        bus.req   <= 1'b0;
                        bus.we    <= 1'b0;
                        bus.addr  <= '0;
                        bus.sel   <= '0;
                        bus.wdata <= '0;
                        discard_q <= 1'b0;
                        if (!discard_q && !flush_i && !is_store_op(lat_aluop)) begin
                            wd_o    <= lat_wd;
                            wreg_o  <= lat_wreg;
                            wdata_o <= load_data;
                        end
                    end else if (flush_i) begin
                        // The access still completes; only its result is dropped.
                        discard_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed stimulus pushes expectations,
// a negedge monitor pops and compares bus requests, write-backs and misalign pulses.
module tb_mem_stage;
    import mem_stage_pkg::*;

    typedef struct {
        logic [4:0]  wd;
        logic [31:0] data;
    } wb_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } req_t;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic        flush_i;
    logic [7:0]  aluop_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic [31:0] mem_addr_i;
    logic [31:0] reg2_i;
    logic        stallreq_o;
    logic        misalign_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;

    mem_stage_if #(.BUS_W(32)) bus ();

    mem_stage dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .flush_i    (flush_i),
        .aluop_i    (aluop_i),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .wdata_i    (wdata_i),
        .mem_addr_i (mem_addr_i),
        .reg2_i     (reg2_i),
        .bus        (bus),
        .stallreq_o (stallreq_o),
        .misalign_o (misalign_o),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o)
    );

    int   pass_cnt = 0;
    int   total_cnt = 0;
    wb_t  wb_q[$];
    req_t req_q[$];
    logic mis_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: consumes expectations whenever the DUT presents an output.
    initial begin
        logic prev_req;
        wb_t  e_wb;
        req_t e_req;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_req = 1'b0;
            end else begin
                if (wreg_o) begin
                    check("wb_expected", 32'(wb_q.size() != 0), 32'd1);
                    if (wb_q.size() != 0) begin
                        e_wb = wb_q.pop_front();
                        check("wb_wd", 32'(wd_o), 32'(e_wb.wd));
                        check("wb_data", wdata_o, e_wb.data);
                    end
                end
                if (misalign_o) begin
                    check("mis_expected", 32'(mis_q.size() != 0), 32'd1);
                    if (mis_q.size() != 0) void'(mis_q.pop_front());
                end
                if (bus.req && !prev_req) begin
                    check("req_expected", 32'(req_q.size() != 0), 32'd1);
                    if (req_q.size() != 0) begin
                        e_req = req_q.pop_front();
                        check("req_we", 32'(bus.we), 32'(e_req.we));
                        check("req_addr", bus.addr, e_req.addr);
                        check("req_sel", 32'(bus.sel), 32'(e_req.sel));
                        check("req_wdata", bus.wdata, e_req.wdata);
                    end
                end
                prev_req = bus.req;
            end
        end
    end

    task automatic alu_op(input string tag, input logic [7:0] op, input logic [4:0] wd,
                          input logic wreg, input logic [31:0] data, input logic valid,
                          input logic flush, input logic exp_wb);
        if (exp_wb) wb_q.push_back('{wd: wd, data: data});
        @(posedge clk); #1;
        aluop_i = op; wd_i = wd; wreg_i = wreg; wdata_i = data;
        mem_addr_i = 32'h0; reg2_i = 32'h0; valid_i = valid; flush_i = flush;
        @(negedge clk);
        check({tag, "_stall"}, 32'(stallreq_o), 32'd0);
        @(posedge clk); #1;
        valid_i = 1'b0; flush_i = 1'b0;
        check({tag, "_wreg"}, 32'(wreg_o), 32'(exp_wb));
    endtask

    task automatic mem_access(input string tag, input logic [7:0] op, input logic [31:0] addr,
                              input logic [31:0] reg2, input logic [4:0] wd,
                              input logic [31:0] rdata, input int delay, input int flush_at,
                              input int exp_stall, input logic exp_we,
                              input logic [31:0] exp_addr, input logic [3:0] exp_sel,
                              input logic [31:0] exp_bwdata, input logic exp_wb,
                              input logic [31:0] exp_load);
        req_q.push_back('{we: exp_we, addr: exp_addr, sel: exp_sel, wdata: exp_bwdata});
        if (exp_wb) wb_q.push_back('{wd: wd, data: exp_load});
        @(posedge clk); #1;
        aluop_i = op; mem_addr_i = addr; reg2_i = reg2; wd_i = wd; wreg_i = 1'b1;
        wdata_i = 32'hCAFE_0000; valid_i = 1'b1; flush_i = 1'b0;
        fork
            begin
                int   waited;
                logic seen;
                waited = 0;
                seen   = 1'b0;
                while (!seen && waited < 20) begin
                    @(negedge clk);
                    seen = bus.req;
                    waited++;
                end
                check({tag, "_req_seen"}, 32'(seen), 32'd1);
                for (int c = 0; c < delay; c++) begin
                    @(posedge clk); #1;
                    flush_i = (c == flush_at);
                    if (c == flush_at) valid_i = 1'b0;
                end
                flush_i = 1'b0;
                check({tag, "_req_held"}, 32'(bus.req), 32'd1);
                bus.ack = 1'b1; bus.rdata = rdata;
                @(posedge clk); #1;
                bus.ack = 1'b0; bus.rdata = 32'h0; valid_i = 1'b0;
            end
            begin
                int  n;
                logic done;
                n    = 0;
                done = 1'b0;
                for (int i = 0; i < 40 && !done; i++) begin
                    @(negedge clk);
                    if (stallreq_o) n++;
                    else done = 1'b1;
                end
                check({tag, "_stall_cycles"}, 32'(n), 32'(exp_stall));
            end
        join
        check({tag, "_wreg_after"}, 32'(wreg_o), 32'(exp_wb));
        check({tag, "_req_dropped"}, 32'(bus.req), 32'd0);
    endtask

    task automatic misaligned(input string tag, input logic [7:0] op, input logic [31:0] addr,
                              input logic [31:0] reg2, input logic [4:0] wd);
        mis_q.push_back(1'b1);
        @(posedge clk); #1;
        aluop_i = op; mem_addr_i = addr; reg2_i = reg2; wd_i = wd; wreg_i = 1'b1;
        wdata_i = 32'h0; valid_i = 1'b1; flush_i = 1'b0;
        @(negedge clk);
        check({tag, "_stall"}, 32'(stallreq_o), 32'd0);
        @(posedge clk); #1;
        valid_i = 1'b0;
        check({tag, "_pulse"}, 32'(misalign_o), 32'd1);
        check({tag, "_wreg"}, 32'(wreg_o), 32'd0);
        @(negedge clk);
        check({tag, "_noreq"}, 32'(bus.req), 32'd0);
        @(posedge clk); #1;
        check({tag, "_pulse_end"}, 32'(misalign_o), 32'd0);
    endtask

    initial begin
        rst = 1'b0; valid_i = 1'b0; flush_i = 1'b0; aluop_i = 8'h0; wd_i = 5'd0;
        wreg_i = 1'b0; wdata_i = 32'h0; mem_addr_i = 32'h0; reg2_i = 32'h0;
        bus.ack = 1'b0; bus.rdata = 32'h0;
        #3;
        check("rst_req", 32'(bus.req), 32'd0);
        check("rst_we_sel", {27'd0, bus.we, bus.sel}, 32'd0);
        check("rst_addr", bus.addr, 32'd0);
        check("rst_bwdata", bus.wdata, 32'd0);
        check("rst_wb", {26'd0, wreg_o, wd_o}, 32'd0);
        check("rst_wdata", wdata_o, 32'd0);
        check("rst_stall_mis", {30'd0, stallreq_o, misalign_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        alu_op("or_pass", EXE_OR_OP, 5'd5, 1'b1, 32'h0000_F0F0, 1'b1, 1'b0, 1'b1);
        alu_op("or_flush", EXE_OR_OP, 5'd6, 1'b1, 32'h1234_5678, 1'b1, 1'b1, 1'b0);
        alu_op("or_invalid", EXE_OR_OP, 5'd7, 1'b1, 32'h8765_4321, 1'b0, 1'b0, 1'b0);

        mem_access("lb", EXE_LB_OP, 32'h0000_1002, 32'h0, 5'd7, 32'h1122_80FF, 3, -1, 4,
                   1'b0, 32'h0000_1000, 4'b0010, 32'h0, 1'b1, 32'hFFFF_FF80);
        mem_access("sh", EXE_SH_OP, 32'h0000_2002, 32'hABCD_1234, 5'd8, 32'h0, 1, -1, 2,
                   1'b1, 32'h0000_2000, 4'b0011, 32'h1234_1234, 1'b0, 32'h0);
        misaligned("lw_mis", EXE_LW_OP, 32'h0000_3001, 32'h0, 5'd3);
        misaligned("sh_mis", EXE_SH_OP, 32'h0000_2001, 32'h5555_AAAA, 5'd4);
        mem_access("lhu_flush", EXE_LHU_OP, 32'h0000_4000, 32'h0, 5'd9, 32'h8001_BEEF, 3, 0, 4,
                   1'b0, 32'h0000_4000, 4'b1100, 32'h0, 1'b0, 32'h0);
        mem_access("lh", EXE_LH_OP, 32'h0000_7000, 32'h0, 5'd9, 32'h8F00_1234, 2, -1, 3,
                   1'b0, 32'h0000_7000, 4'b1100, 32'h0, 1'b1, 32'hFFFF_8F00);
        mem_access("sb", EXE_SB_OP, 32'h0000_6003, 32'h0000_00A5, 5'd2, 32'h0, 1, -1, 2,
                   1'b1, 32'h0000_6000, 4'b0001, 32'hA5A5_A5A5, 1'b0, 32'h0);
        mem_access("lbu", EXE_LBU_OP, 32'h0000_6000, 32'h0, 5'd10, 32'h8012_3456, 1, -1, 2,
                   1'b0, 32'h0000_6000, 4'b1000, 32'h0, 1'b1, 32'h0000_0080);
        mem_access("lw", EXE_LW_OP, 32'h0000_8004, 32'h0, 5'd11, 32'hDEAD_BEEF, 1, -1, 2,
                   1'b0, 32'h0000_8004, 4'b1111, 32'h0, 1'b1, 32'hDEAD_BEEF);
        mem_access("lhu_hi", EXE_LHU_OP, 32'h0000_4002, 32'h0, 5'd12, 32'h1234_ABCD, 1, -1, 2,
                   1'b0, 32'h0000_4000, 4'b0011, 32'h0, 1'b1, 32'h0000_ABCD);
        mem_access("sw", EXE_SW_OP, 32'h0000_9008, 32'h0BAD_F00D, 5'd13, 32'h0, 2, -1, 3,
                   1'b1, 32'h0000_9008, 4'b1111, 32'h0BAD_F00D, 1'b0, 32'h0);

        // Ack with nothing outstanding must be ignored.
        @(posedge clk); #1;
        bus.ack = 1'b1; bus.rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check("idle_ack_stall", 32'(stallreq_o), 32'd0);
        @(posedge clk); #1;
        bus.ack = 1'b0; bus.rdata = 32'h0;
        check("idle_ack_wreg", 32'(wreg_o), 32'd0);

        // Reset while an access is outstanding.
        req_q.push_back('{we: 1'b0, addr: 32'h0000_5000, sel: 4'b1111, wdata: 32'h0});
        @(posedge clk); #1;
        aluop_i = EXE_LW_OP; mem_addr_i = 32'h0000_5000; wd_i = 5'd14; wreg_i = 1'b1;
        valid_i = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                seen = bus.req;
            end
            check("rstb_req_seen", 32'(seen), 32'd1);
        end
        @(posedge clk); #3;
        rst = 1'b0; valid_i = 1'b0;
        #1;
        check("rstb_req_drop", 32'(bus.req), 32'd0);
        check("rstb_stall", 32'(stallreq_o), 32'd0);
        check("rstb_wb", {26'd0, wreg_o, wd_o}, 32'd0);
        check("rstb_wdata", wdata_o, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        bus.ack = 1'b1; bus.rdata = 32'h1234_5678;
        @(posedge clk); #1;
        bus.ack = 1'b0; bus.rdata = 32'h0;
        check("rstb_ack_wreg", 32'(wreg_o), 32'd0);
        check("rstb_ack_wdata", wdata_o, 32'd0);
        repeat (3) @(negedge clk);
        check("rstb_req_idle", 32'(bus.req), 32'd0);

        check("wb_queue_drained", 32'(wb_q.size()), 32'd0);
        check("req_queue_drained", 32'(req_q.size()), 32'd0);
        check("mis_queue_drained", 32'(mis_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
